alu_exec_sequencer: RTL and testbench

Multi-cycle execute sequencer that sits directly upstream of the `ALU` and downstream of the instruction decoder in cpu2. On a `start` request it fetches two operands from data RAM, presents them with the operation code to the combinational `ALU`, captures the result and writes it back to a destination RAM address. It owns the single RAM port for the whole operation and reports completion with a one-cycle `done` pulse.

---
 rtl/alu_exec_sequencer_pkg.sv | 28 ++
 rtl/alu_exec_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_exec_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_sequencer_pkg.sv
// Shared definitions for the execute sequencer: word/RAM/opcode sizes,
// ALU operation codes and the sequencer FSM state encodings.
package alu_exec_sequencer_pkg;

  localparam int MEMORY_WORD_SIZE = 8;
  localparam int RAM_SIZE         = 256;
  localparam int OPERATOR_SIZE    = 2;
  localparam int ADDR_WIDTH       = $clog2(RAM_SIZE);

  localparam logic [OPERATOR_SIZE-1:0] ALU_OP_AND = 2'd0;
  localparam logic [OPERATOR_SIZE-1:0] ALU_OP_OR  = 2'd1;
  localparam logic [OPERATOR_SIZE-1:0] ALU_OP_XOR = 2'd2;

  typedef enum logic [2:0] {
    SEQ_ST_IDLE   = 3'd0,
    SEQ_ST_RD_A   = 3'd1,
    SEQ_ST_RD_B   = 3'd2,
    SEQ_ST_WAIT_B = 3'd3,
    SEQ_ST_EXEC   = 3'd4,
    SEQ_ST_WRITE  = 3'd5,
    SEQ_ST_DONE   = 3'd6
  } seq_state_e;

  function automatic logic is_legal_op(input logic [OPERATOR_SIZE-1:0] op);
    return (op == ALU_OP_AND) || (op == ALU_OP_OR) || (op == ALU_OP_XOR);
  endfunction

endpackage

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute sequencer: reads two operands from RAM, feeds the
// external combinational ALU, captures the result and writes it back.
module alu_exec_sequencer
  import alu_exec_sequencer_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [OPERATOR_SIZE-1:0]    op_in,
  input  logic [ADDR_WIDTH-1:0]       addr_a,
  input  logic [ADDR_WIDTH-1:0]       addr_b,
  input  logic [ADDR_WIDTH-1:0]       addr_dst,
  output logic                        busy,
  output logic                        done,
  output logic                        illegal_op,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic                        mem_rd,
  input  logic [MEMORY_WORD_SIZE-1:0] mem_rdata,
  output logic                        mem_wr,
  output logic [MEMORY_WORD_SIZE-1:0] mem_wdata,
  output logic [MEMORY_WORD_SIZE-1:0] alu_operand_a,
  output logic [MEMORY_WORD_SIZE-1:0] alu_operand_b,
  output logic [OPERATOR_SIZE-1:0]    alu_operation,
  input  logic [MEMORY_WORD_SIZE-1:0] alu_result,
  output logic [MEMORY_WORD_SIZE-1:0] last_result
);

  seq_state_e                  state_q;
  logic [ADDR_WIDTH-1:0]       addr_b_q, addr_dst_q;
  logic                        busy_q, done_q, illegal_op_q, mem_rd_q, mem_wr_q;
  logic [ADDR_WIDTH-1:0]       mem_addr_q;
  logic [MEMORY_WORD_SIZE-1:0] mem_wdata_q, operand_a_q, operand_b_q, last_result_q;
  logic [OPERATOR_SIZE-1:0]    operation_q;

  // Moore outputs are registered one step ahead: each branch loads the
  // strobe/address values belonging to the state being entered, so they
  // depend on state alone and the async reset clears them instantly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEQ_ST_IDLE;
      addr_b_q      <= '0;
      addr_dst_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      illegal_op_q  <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      operation_q   <= '0;
      last_result_q <= '0;
    end else begin
      // NOTE: defaults first, overridden below; with <= the last write wins,
      // so pulse outputs fall back to 0 in every state that doesn't set them.
      done_q       <= 1'b0;
      illegal_op_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      unique case (state_q)
        SEQ_ST_IDLE: begin
          if (start) begin
            operation_q <= op_in;
            addr_b_q    <= addr_b;
            addr_dst_q  <= addr_dst;
            busy_q      <= 1'b1;
            mem_rd_q    <= 1'b1;
            mem_addr_q  <= addr_a;
            state_q     <= SEQ_ST_RD_A;
          end
        end
        SEQ_ST_RD_A: begin
          mem_rd_q   <= 1'b1;
          mem_addr_q <= addr_b_q;
          state_q    <= SEQ_ST_RD_B;
        end
        SEQ_ST_RD_B: begin
          operand_a_q <= mem_rdata;
          state_q     <= SEQ_ST_WAIT_B;
        end
        SEQ_ST_WAIT_B: begin
          operand_b_q <= mem_rdata;
          state_q     <= SEQ_ST_EXEC;
        end
        SEQ_ST_EXEC: begin
          if (is_legal_op(operation_q)) begin
            last_result_q <= alu_result;
            mem_wr_q      <= 1'b1;
            mem_addr_q    <= addr_dst_q;
            mem_wdata_q   <= alu_result;
            state_q       <= SEQ_ST_WRITE;
          end else begin
            done_q       <= 1'b1;
            illegal_op_q <= 1'b1;
            state_q      <= SEQ_ST_DONE;
          end
        end
        SEQ_ST_WRITE: begin
          done_q  <= 1'b1;
          state_q <= SEQ_ST_DONE;
        end
        SEQ_ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= SEQ_ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= SEQ_ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign illegal_op    = illegal_op_q;
  assign mem_rd        = mem_rd_q;
  assign mem_wr        = mem_wr_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign alu_operand_a = operand_a_q;
  assign alu_operand_b = operand_b_q;
  assign alu_operation = operation_q;
  assign last_result   = last_result_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a behavioural RAM and ALU.
module tb_alu_exec_sequencer;
  import alu_exec_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op_in;
  logic [7:0] addr_a, addr_b, addr_dst;
  logic       busy, done, illegal_op, mem_rd, mem_wr;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;
  logic [7:0] alu_operand_a, alu_operand_b, alu_result, last_result;
  logic [1:0] alu_operation;

  logic [7:0] ram [256];
  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  alu_exec_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_in(op_in),
    .addr_a(addr_a), .addr_b(addr_b), .addr_dst(addr_dst),
    .busy(busy), .done(done), .illegal_op(illegal_op),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_operation(alu_operation), .alu_result(alu_result),
    .last_result(last_result)
  );

  // Synchronous single-port RAM: read data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  always_comb begin
    case (alu_operation)
      ALU_OP_AND: alu_result = alu_operand_a & alu_operand_b;
      ALU_OP_OR:  alu_result = alu_operand_a | alu_operand_b;
      ALU_OP_XOR: alu_result = alu_operand_a ^ alu_operand_b;
      default:    alu_result = 8'hEE;
    endcase
  end

  // Invariants checked every cycle.
  always @(negedge clk) begin
    if (done) done_count++;
    n_cmp++;
    if (mem_rd && mem_wr) begin
      n_bad++;
      $display("FAIL inv_rd_wr got rd=%b wr=%b exp not both", mem_rd, mem_wr);
    end
    n_cmp++;
    if (busy !== (dut.state_q != SEQ_ST_IDLE)) begin
      n_bad++;
      $display("FAIL inv_busy got %b exp %b", busy, dut.state_q != SEQ_ST_IDLE);
    end
    n_cmp++;
    if (!mem_rd && !mem_wr && mem_addr !== 8'h00) begin
      n_bad++;
      $display("FAIL inv_addr_idle got %h exp 00", mem_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns in cycle 1 of the op.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, b, dst);
    op_in = op; addr_a = a; addr_b = b; addr_dst = dst;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles (cycle 1 = first after the accepting edge) up to done.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    logic [66:0] got;
    got = {busy, done, illegal_op, mem_rd, mem_wr, mem_addr, mem_wdata,
           alu_operand_a, alu_operand_b, alu_operation, last_result, 8'h00, 8'h00};
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL %s got %h exp 0", tag, got);
    end
    n_cmp++;
    if (dut.state_q !== SEQ_ST_IDLE) begin
      n_bad++;
      $display("FAIL %s_state got %0d exp %0d", tag, dut.state_q, SEQ_ST_IDLE);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    check_reset_values("reset_vals");
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_and();
    ram[8'h10] = 8'hF0; ram[8'h11] = 8'h3C; ram[8'h12] = 8'h00;
    issue(ALU_OP_AND, 8'h10, 8'h11, 8'h12);
    n_cmp++;
    if ({busy, mem_rd, mem_wr, mem_addr} !== {3'b110, 8'h10}) begin
      n_bad++;
      $display("FAIL and_c1 got %b%b%b %h exp 110 10", busy, mem_rd, mem_wr, mem_addr);
    end
    tick();
    n_cmp++;
    if ({mem_rd, mem_addr} !== {1'b1, 8'h11}) begin
      n_bad++;
      $display("FAIL and_c2 got %b %h exp 1 11", mem_rd, mem_addr);
    end
    tick();
    n_cmp++;
    if ({mem_rd, alu_operand_a, alu_operation} !== {1'b0, 8'hF0, ALU_OP_AND}) begin
      n_bad++;
      $display("FAIL and_c3 got %b %h %h exp 0 f0 0", mem_rd, alu_operand_a, alu_operation);
    end
    tick();
    n_cmp++;
    if (alu_operand_b !== 8'h3C) begin
      n_bad++;
      $display("FAIL and_c4_opb got %h exp 3c", alu_operand_b);
    end
    tick();
    n_cmp++;
    if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 8'h12, 8'h30}) begin
      n_bad++;
      $display("FAIL and_c5_write got %b %h %h exp 1 12 30", mem_wr, mem_addr, mem_wdata);
    end
    tick();
    n_cmp++;
    if ({done, illegal_op, last_result, ram[8'h12]} !== {2'b10, 8'h30, 8'h30}) begin
      n_bad++;
      $display("FAIL and_c6_done got %b%b %h %h exp 10 30 30", done, illegal_op, last_result, ram[8'h12]);
    end
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL and_c7_idle got %b%b exp 00", busy, done);
    end
  endtask

  task automatic test_illegal();
    int c;
    int wr_before;
    wr_before = wr_count;
    ram[8'h30] = 8'h77;
    issue(2'd3, 8'h10, 8'h11, 8'h30);
    wait_done(c);
    n_cmp++;
    if (c !== 5) begin
      n_bad++;
      $display("FAIL ill_done_cycle got %0d exp 5", c);
    end
    n_cmp++;
    if ({illegal_op, last_result} !== {1'b1, 8'h30}) begin
      n_bad++;
      $display("FAIL ill_flags got %b %h exp 1 30", illegal_op, last_result);
    end
    tick();
    n_cmp++;
    if (wr_count !== wr_before || ram[8'h30] !== 8'h77 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ill_no_write got wr=%0d ram=%h busy=%b exp wr=%0d ram=77 busy=0",
               wr_count, ram[8'h30], busy, wr_before);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    ram[8'h20] = 8'h00;
    op_in = ALU_OP_OR; addr_a = 8'h10; addr_b = 8'h11; addr_dst = 8'h20;
    start = 1'b1;
    tick();
    op_in = ALU_OP_XOR;
    wait_done(c);
    n_cmp++;
    if ({c == 6, last_result} !== {1'b1, 8'hFC}) begin
      n_bad++;
      $display("FAIL b2b_first got cyc=%0d res=%h exp cyc=6 res=fc", c, last_result);
    end
    tick();
    n_cmp++;
    if ({busy, ram[8'h20]} !== {1'b0, 8'hFC}) begin
      n_bad++;
      $display("FAIL b2b_idle_gap got busy=%b ram=%h exp busy=0 ram=fc", busy, ram[8'h20]);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, mem_rd, mem_addr} !== {2'b11, 8'h10}) begin
      n_bad++;
      $display("FAIL b2b_second_start got %b%b %h exp 11 10", busy, mem_rd, mem_addr);
    end
    wait_done(c);
    tick();
    n_cmp++;
    if ({c == 6, last_result, ram[8'h20]} !== {1'b1, 8'hCC, 8'hCC}) begin
      n_bad++;
      $display("FAIL b2b_second got cyc=%0d res=%h ram=%h exp cyc=6 res=cc ram=cc",
               c, last_result, ram[8'h20]);
    end
  endtask

  task automatic test_overlap();
    int c;
    ram[8'h05] = 8'hA5;
    issue(ALU_OP_XOR, 8'h05, 8'h05, 8'h05);
    wait_done(c);
    tick();
    n_cmp++;
    if ({c == 6, last_result, ram[8'h05]} !== {1'b1, 8'h00, 8'h00}) begin
      n_bad++;
      $display("FAIL overlap got cyc=%0d res=%h ram=%h exp cyc=6 res=00 ram=00",
               c, last_result, ram[8'h05]);
    end
  endtask

  task automatic test_reset_in_write();
    int d_before;
    ram[8'h40] = 8'h55;
    issue(ALU_OP_AND, 8'h10, 8'h11, 8'h40);
    repeat (4) tick();
    n_cmp++;
    if ({mem_wr, mem_addr} !== {1'b1, 8'h40}) begin
      n_bad++;
      $display("FAIL rst_wr_pre got %b %h exp 1 40", mem_wr, mem_addr);
    end
    d_before = done_count;
    #2 reset = 1'b1;
    #1;
    check_reset_values("rst_async");
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (ram[8'h40] !== 8'h55 || done_count !== d_before) begin
      n_bad++;
      $display("FAIL rst_no_write got ram=%h dones=%0d exp ram=55 dones=%0d",
               ram[8'h40], done_count, d_before);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
    start = 1'b0; op_in = 2'd0; addr_a = 8'h00; addr_b = 8'h00; addr_dst = 8'h00;
    test_reset();
    test_and();
    test_illegal();
    test_back_to_back();
    test_overlap();
    test_reset_in_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
